dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arbiter.sv | 50 +++++
 tb/tb_dmem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, debug and data-memory bus signals of the data-memory arbiter
//   core_*   : pipeline MEM-stage request, stall and load return
//   dbg_*    : debug/loader request, one-cycle grant and read return
//   mem_*    : single data-memory port with 1-cycle synchronous read latency
//   slave    : arbiter view; master: view of the surrounding core/debug/memory
interface dmem_arbiter_if;
    logic        core_req, core_we, core_stall, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [2:0]  core_funct3;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        output core_stall, core_rvalid, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata
    );
    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        input  core_stall, core_rvalid, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core and a debug port
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : core request/stall/load return, debug request/grant/read return, memory port
module dmem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CORE_RD, DBG_RD} state_t;
    localparam logic [2:0] SMAX = 3'(STARVE_MAX);
    state_t      state;
    logic [2:0]  starve_cnt;
    logic [31:0] core_rdata_q, dbg_rdata_q;
    logic        idle, dbg_win;
    // dbg_win is only meaningful while idle; every use is gated by idle or mem_en
    always_comb begin
        idle            = state == IDLE && !reset;
        dbg_win         = bus.dbg_req && (!bus.core_req || starve_cnt == SMAX);
        bus.mem_en      = idle && (bus.core_req || bus.dbg_req);
        bus.dbg_gnt     = idle && dbg_win;
        bus.mem_we      = bus.mem_en && (dbg_win ? bus.dbg_we : bus.core_we);
        bus.mem_addr    = dbg_win ? bus.dbg_addr : bus.core_addr;
        bus.mem_wdata   = dbg_win ? bus.dbg_wdata : bus.core_wdata;
        bus.mem_funct3  = dbg_win ? 3'b010 : bus.core_funct3;
        bus.core_rvalid = state == CORE_RD;
        bus.dbg_rvalid  = state == DBG_RD;
        bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : core_rdata_q;
        bus.dbg_rdata   = bus.dbg_rvalid ? bus.mem_rdata : dbg_rdata_q;
        // a core store completes in its issue cycle; a core load is released in CORE_RD
        bus.core_stall  = !reset && bus.core_req &&
                          !((idle && !dbg_win && bus.core_we) || state == CORE_RD);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_cnt <= bus.dbg_gnt ? 3'd0 :
                          (bus.dbg_req && starve_cnt < SMAX) ? starve_cnt + 3'd1 : starve_cnt;
            if (bus.core_rvalid) core_rdata_q <= bus.mem_rdata;
            if (bus.dbg_rvalid) dbg_rdata_q <= bus.mem_rdata;
            state <= (!bus.mem_en || bus.mem_we) ? IDLE : dbg_win ? DBG_RD : CORE_RD;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic clk = 0;
    logic reset;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mem [0:255];
    dmem_arbiter_if bus();
    dmem_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial bus.mem_rdata = '0;
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end

    task automatic idle_inputs();
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0; bus.core_funct3 = 3'b010;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; bus.core_req = 1; bus.dbg_req = 1;
        #1;
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %b want 0", bus.mem_en); end
        n_cmp++; if (bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", bus.core_stall); end
        n_cmp++; if (bus.dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt got %b want 0", bus.dbg_gnt); end
        n_cmp++; if ({bus.core_rvalid, bus.dbg_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid got %b want 00", {bus.core_rvalid, bus.dbg_rvalid}); end
        n_cmp++; if ({bus.core_rdata, bus.dbg_rdata} !== 64'd0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", {bus.core_rdata, bus.dbg_rdata}); end
        @(negedge clk); idle_inputs(); reset = 0;
    endtask

    task automatic test_core_store();
        @(negedge clk);
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h10; bus.core_wdata = 32'hDEADBEEF;
        #1;
        n_cmp++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin n_bad++; $display("FAIL st_en_we got %b want 11", {bus.mem_en, bus.mem_we}); end
        n_cmp++; if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_addr_data got %h/%h want 10/deadbeef", bus.mem_addr, bus.mem_wdata); end
        n_cmp++; if (bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL st_stall got %b want 0", bus.core_stall); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.core_stall !== 1'b0) begin n_bad++; $display("FAIL st_after got en=%b stall=%b want 0/0", bus.mem_en, bus.core_stall); end
    endtask

    task automatic test_core_load();
        @(negedge clk);
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h10;
        #1;
        n_cmp++; if ({bus.mem_en, bus.mem_we, bus.core_stall} !== 3'b101) begin n_bad++; $display("FAIL ld_issue got en/we/stall=%b want 101", {bus.mem_en, bus.mem_we, bus.core_stall}); end
        @(negedge clk); #1;
        n_cmp++; if ({bus.core_rvalid, bus.core_stall, bus.mem_en} !== 3'b100) begin n_bad++; $display("FAIL ld_ret got rvalid/stall/en=%b want 100", {bus.core_rvalid, bus.core_stall, bus.mem_en}); end
        n_cmp++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_data got %h want deadbeef", bus.core_rdata); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_hold got %b/%h want 0/deadbeef", bus.core_rvalid, bus.core_rdata); end
    endtask

    task automatic test_dbg_write();
        @(negedge clk);
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h20; bus.dbg_wdata = 32'h1234;
        #1;
        n_cmp++; if ({bus.dbg_gnt, bus.mem_en, bus.mem_we} !== 3'b111) begin n_bad++; $display("FAIL dw_issue got gnt/en/we=%b want 111", {bus.dbg_gnt, bus.mem_en, bus.mem_we}); end
        n_cmp++; if (bus.mem_addr !== 32'h20 || bus.mem_funct3 !== 3'b010 || bus.mem_wdata !== 32'h1234) begin n_bad++; $display("FAIL dw_bus got %h/%b/%h want 20/010/1234", bus.mem_addr, bus.mem_funct3, bus.mem_wdata); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (bus.dbg_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL dw_after got gnt=%b en=%b want 0/0", bus.dbg_gnt, bus.mem_en); end
    endtask

    task automatic test_starve();
        logic [7:0] e_en = 8'b01010101, e_gnt = 8'b00010000, e_stall = 8'b01110101;
        logic [7:0] e_crv = 8'b10001010, e_drv = 8'b00100000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h10;
            bus.dbg_req = i < 5; bus.dbg_we = 0; bus.dbg_addr = 32'h20;
            #1;
            n_cmp++; if ({bus.mem_en, bus.dbg_gnt, bus.core_stall, bus.core_rvalid, bus.dbg_rvalid} !== {e_en[i], e_gnt[i], e_stall[i], e_crv[i], e_drv[i]}) begin
                n_bad++; $display("FAIL starve_c%0d got en/gnt/stall/crv/drv=%b want %b", i, {bus.mem_en, bus.dbg_gnt, bus.core_stall, bus.core_rvalid, bus.dbg_rvalid}, {e_en[i], e_gnt[i], e_stall[i], e_crv[i], e_drv[i]});
            end
            if (i == 4) begin
                n_cmp++; if (bus.mem_addr !== 32'h20) begin n_bad++; $display("FAIL starve_addr got %h want 20", bus.mem_addr); end
            end
            if (i == 5) begin
                n_cmp++; if (bus.dbg_rdata !== 32'h1234) begin n_bad++; $display("FAIL starve_drdata got %h want 1234", bus.dbg_rdata); end
            end
            if (i == 7) begin
                n_cmp++; if (bus.core_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL starve_crdata got %h want deadbeef", bus.core_rdata); end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_reset_in_rd();
        @(negedge clk);
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h10;
        @(negedge clk); reset = 1; #1;
        n_cmp++; if ({bus.core_rvalid, bus.core_stall, bus.mem_en, bus.dbg_gnt} !== 4'b0000) begin n_bad++; $display("FAIL rrd_outs got rvalid/stall/en/gnt=%b want 0000", {bus.core_rvalid, bus.core_stall, bus.mem_en, bus.dbg_gnt}); end
        n_cmp++; if (bus.core_rdata !== 32'd0 || bus.dbg_rdata !== 32'd0) begin n_bad++; $display("FAIL rrd_data got %h/%h want 0/0", bus.core_rdata, bus.dbg_rdata); end
        @(negedge clk); reset = 0; #1;
        n_cmp++; if ({bus.core_rvalid, bus.mem_en, bus.core_stall} !== 3'b011) begin n_bad++; $display("FAIL rrd_first got rvalid/en/stall=%b want 011", {bus.core_rvalid, bus.mem_en, bus.core_stall}); end
        @(negedge clk); #1;
        n_cmp++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rrd_load got %b/%h want 1/deadbeef", bus.core_rvalid, bus.core_rdata); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h30; bus.core_wdata = 32'hCAFEF00D;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h20;
        #1;
        n_cmp++; if ({bus.mem_en, bus.mem_we, bus.dbg_gnt, bus.core_stall} !== 4'b1100 || bus.mem_addr !== 32'h30) begin n_bad++; $display("FAIL b2b_st got en/we/gnt/stall=%b addr=%h want 1100 30", {bus.mem_en, bus.mem_we, bus.dbg_gnt, bus.core_stall}, bus.mem_addr); end
        @(negedge clk); bus.core_we = 0; #1;
        n_cmp++; if ({bus.mem_en, bus.mem_we, bus.dbg_gnt, bus.core_stall} !== 4'b1001 || bus.mem_addr !== 32'h30) begin n_bad++; $display("FAIL b2b_ld got en/we/gnt/stall=%b addr=%h want 1001 30", {bus.mem_en, bus.mem_we, bus.dbg_gnt, bus.core_stall}, bus.mem_addr); end
        @(negedge clk); #1;
        n_cmp++; if ({bus.core_rvalid, bus.mem_en, bus.dbg_gnt} !== 3'b100 || bus.core_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_ret got rvalid/en/gnt=%b data=%h want 100 cafef00d", {bus.core_rvalid, bus.mem_en, bus.dbg_gnt}, bus.core_rdata); end
        @(negedge clk); bus.core_req = 0; #1;
        n_cmp++; if ({bus.dbg_gnt, bus.mem_en, bus.mem_we} !== 3'b110 || bus.mem_addr !== 32'h20) begin n_bad++; $display("FAIL b2b_dbg got gnt/en/we=%b addr=%h want 110 20", {bus.dbg_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr); end
        @(negedge clk); bus.dbg_req = 0; #1;
        n_cmp++; if ({bus.dbg_rvalid, bus.mem_en, bus.dbg_gnt} !== 3'b100 || bus.dbg_rdata !== 32'h1234) begin n_bad++; $display("FAIL b2b_dret got drv/en/gnt=%b data=%h want 100 1234", {bus.dbg_rvalid, bus.mem_en, bus.dbg_gnt}, bus.dbg_rdata); end
        @(negedge clk); #1;
        n_cmp++; if ({bus.dbg_rvalid, bus.mem_en} !== 2'b00 || bus.dbg_rdata !== 32'h1234) begin n_bad++; $display("FAIL b2b_hold got drv/en=%b data=%h want 00 1234", {bus.dbg_rvalid, bus.mem_en}, bus.dbg_rdata); end
    endtask

    initial begin
        test_reset();
        test_core_store();
        test_core_load();
        test_dbg_write();
        test_starve();
        test_reset_in_rd();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
